// File: rtl/avalon_pkg.sv
// Shared types and width helpers for the Avalon-MM bridge.
// Command encodings plus lane/offset sizing derived from the data width.
package avalon_pkg;

  typedef enum logic [1:0] {
    AV_IDLE  = 2'b00,
    AV_READ  = 2'b01,
    AV_WRITE = 2'b10
  } av_cmd_e;

  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction

  function automatic int off_w(input int dw);
    return (dw / 8 > 1) ? $clog2(dw / 8) : 1;
  endfunction

endpackage

// File: rtl/avalon_mm_bridge_if.sv
// Core request/response port plus Avalon-MM master signals.
// master = the bridge, slave = the core and Avalon fabric around it.
interface avalon_mm_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W/8-1:0] req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  logic [ADDR_W-1:0] av_address;
  logic              av_read;
  logic              av_write;
  logic [DATA_W-1:0] av_writedata;
  logic [DATA_W/8-1:0] av_byteenable;
  logic              av_waitrequest;
  logic [DATA_W-1:0] av_readdata;
  logic              av_readdatavalid;

  modport master (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output av_address, av_read, av_write,
    output av_writedata, av_byteenable,
    input  av_waitrequest, av_readdata,
    input  av_readdatavalid
  );

  modport slave (
    output req_valid, req_we, req_addr,
    output req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  av_address, av_read, av_write,
    input  av_writedata, av_byteenable,
    output av_waitrequest, av_readdata,
    output av_readdatavalid
  );
endinterface

// File: rtl/avalon_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, output read from storage flops.
// Pushes while full and pops while empty are ignored.
module avalon_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             full, do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/avalon_mm_bridge.sv
// Core req/rsp to pipelined Avalon-MM bridge with read credits,
// lane-offset tracking and a back-pressurable response FIFO.
module avalon_mm_bridge
  import avalon_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MAX_PENDING = 4,
  parameter bit LANE_ALIGN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  avalon_mm_bridge_if.master bus,
  output logic              err
);
  localparam int BE_W  = lanes(DATA_W);
  localparam int OFF_W = off_w(DATA_W);
  localparam int CR_W  = $clog2(MAX_PENDING + 1);

  av_cmd_e           cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [CR_W-1:0]   credits_q, credits_d;
  logic              err_q, err_d;

  logic busy, done, ready, accept, rd_acc;
  logic rsp_vld, rsp_pop, rdv_ok;
  logic off_empty, rsp_empty;
  logic [OFF_W-1:0]  off_in, off_out;
  logic [DATA_W-1:0] rd_shift;

  assign busy    = (cmd_q != AV_IDLE);
  assign done    = busy & ~bus.av_waitrequest;
  assign ready   = (~busy | done)
                 & (bus.req_we | (credits_q != '0));
  assign accept  = bus.req_valid & ready;
  assign rd_acc  = accept & ~bus.req_we;
  assign rsp_vld = ~rsp_empty;
  assign rsp_pop = rsp_vld & bus.rsp_ready;
  assign rdv_ok  = bus.av_readdatavalid & ~off_empty;

  assign bus.req_ready     = ready;
  assign bus.rsp_valid     = rsp_vld;
  assign bus.av_read       = (cmd_q == AV_READ);
  assign bus.av_write      = (cmd_q == AV_WRITE);
  assign bus.av_address    = addr_q;
  assign bus.av_writedata  = wdata_q;
  assign bus.av_byteenable = be_q;
  assign err               = err_q;

  // A new command may replace one completing this same cycle.
  always_comb begin
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (accept) begin
      cmd_d   = bus.req_we ? AV_WRITE : AV_READ;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      be_d    = bus.req_be;
    end else if (done) begin
      cmd_d = AV_IDLE;
    end
  end

  always_comb begin
    credits_d = credits_q;
    unique case ({rd_acc, rsp_pop})
      2'b10:   credits_d = credits_q - CR_W'(1);
      2'b01:   credits_d = credits_q + CR_W'(1);
      default: ;
    endcase
    err_d = err_q | (bus.av_readdatavalid & off_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= AV_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      credits_q <= CR_W'(MAX_PENDING);
      err_q     <= 1'b0;
    end else begin
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign off_in   = LANE_ALIGN ? bus.req_addr[OFF_W-1:0] : '0;
  assign rd_shift = bus.av_readdata >> {off_out, 3'b000};

  avalon_sync_fifo #(
    .WIDTH (OFF_W),
    .DEPTH (MAX_PENDING)
  ) u_off_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rd_acc),
    .din_i   (off_in),
    .pop_i   (rdv_ok),
    .dout_o  (off_out),
    .empty_o (off_empty)
  );

  avalon_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (MAX_PENDING)
  ) u_rsp_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rdv_ok),
    .din_i   (rd_shift),
    .pop_i   (rsp_pop),
    .dout_o  (bus.rsp_data),
    .empty_o (rsp_empty)
  );
endmodule

// File: tb/tb_avalon_mm_bridge.sv
// Bench for avalon_mm_bridge: directed scenarios then random traffic,
// checked against a queue-based transaction model and slave model.
module tb_avalon_mm_bridge;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err;

  avalon_mm_bridge_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  avalon_mm_bridge #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .MAX_PENDING (MAXP),
    .LANE_ALIGN  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_t;

  cmd_t        cmdq[$];
  rd_t         sq[$];
  logic [1:0]  offq[$];
  logic [31:0] exp_rsp[$];

  int checks, errors;
  int outstanding, cyc, n_pop, n_rd_acc;
  int force_wr, lat_force, start;
  logic err_m, fixed_en, last_acc;
  logic [31:0] fixed_data, last_pop;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic slave_drive();
    rd_t s;
    bus.av_readdatavalid = 1'b0;
    bus.av_readdata      = $urandom;
    if (sq.size() != 0 && sq[0].due <= cyc) begin
      s = sq.pop_front();
      bus.av_readdatavalid = 1'b1;
      bus.av_readdata      = s.data;
    end
    if (force_wr >= 0) bus.av_waitrequest = force_wr[0];
    else bus.av_waitrequest = ($urandom_range(0, 2) == 0);
  endtask

  task automatic tick();
    cmd_t c;
    rd_t s;
    logic exp_rdy;
    logic [1:0] off;
    #1;
    exp_rdy = (cmdq.size() == 0 || !bus.av_waitrequest)
            && (bus.req_we || outstanding < MAXP);
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("rsp_valid", bus.rsp_valid, exp_rsp.size() != 0);
    if (exp_rsp.size() != 0) chk("rsp_data", bus.rsp_data, exp_rsp[0]);
    chk("err", err, err_m);
    if (cmdq.size() == 0) begin
      chk("av_idle", {bus.av_read, bus.av_write}, 2'b00);
    end else begin
      c = cmdq[0];
      chk("av_read", bus.av_read, !c.we);
      chk("av_write", bus.av_write, c.we);
      chk("av_address", bus.av_address, c.addr);
      chk("av_be", bus.av_byteenable, c.be);
      if (c.we) chk("av_wdata", bus.av_writedata, c.wdata);
    end
    last_acc = bus.req_valid && bus.req_ready;
    if (cmdq.size() != 0 && !bus.av_waitrequest) begin
      c = cmdq.pop_front();
      if (!c.we) begin
        s.data = fixed_en ? fixed_data : $urandom;
        s.due  = cyc + ((lat_force > 0) ? lat_force
                                         : int'($urandom_range(1, 3)));
        sq.push_back(s);
      end
    end
    if (last_acc) begin
      c.we    = bus.req_we;
      c.addr  = bus.req_addr;
      c.wdata = bus.req_wdata;
      c.be    = bus.req_be;
      cmdq.push_back(c);
      if (!c.we) begin
        outstanding++;
        n_rd_acc++;
        offq.push_back(c.addr[1:0]);
      end
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      last_pop = bus.rsp_data;
      n_pop++;
      outstanding--;
      if (exp_rsp.size() != 0) void'(exp_rsp.pop_front());
    end
    if (bus.av_readdatavalid) begin
      if (offq.size() != 0) begin
        off = offq.pop_front();
        exp_rsp.push_back(bus.av_readdata >> (8 * off));
      end else begin
        err_m = 1'b1;
      end
    end
    @(negedge clk);
    cyc++;
    slave_drive();
  endtask

  task automatic do_reset(input int n, input bit keep_sq);
    rst = 1'b1;
    bus.req_valid        = 1'b0;
    bus.av_readdatavalid = 1'b0;
    bus.av_waitrequest   = 1'b0;
    #1;
    chk("rst_av_read", bus.av_read, 0);
    chk("rst_av_write", bus.av_write, 0);
    chk("rst_av_addr", bus.av_address, 0);
    chk("rst_av_wdata", bus.av_writedata, 0);
    chk("rst_av_be", bus.av_byteenable, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_err", err, 0);
    cmdq.delete();
    offq.delete();
    exp_rsp.delete();
    if (!keep_sq) sq.delete();
    outstanding = 0;
    err_m = 1'b0;
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b0;
    slave_drive();
  endtask

  task automatic req(input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
  endtask

  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0;
    bus.req_wdata = 0; bus.req_be = 0; bus.rsp_ready = 0;
    bus.av_waitrequest = 0; bus.av_readdata = 0;
    bus.av_readdatavalid = 0;
    checks = 0; errors = 0; cyc = 0; n_pop = 0; n_rd_acc = 0;
    outstanding = 0; force_wr = 0; lat_force = 0;
    fixed_en = 0; fixed_data = 0; err_m = 0; last_pop = 0;
    #2;
    do_reset(2, 1'b0);

    // single lane-shifted read
    bus.rsp_ready = 1'b1;
    fixed_en = 1'b1;
    fixed_data = 32'hAABBCCDD;
    req(1'b0, 32'h103, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    repeat (5) tick();
    chk("t1_data", last_pop, 32'h000000AA);
    chk("t1_npop", n_pop, 1);
    fixed_en = 1'b0;

    // write held by waitrequest
    force_wr = 1;
    req(1'b1, 32'h40, 32'h12345678, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    force_wr = 0;
    repeat (3) tick();
    chk("t2_npop", n_pop, 1);

    // credit exhaustion with rsp_ready low
    bus.rsp_ready = 1'b0;
    start = n_rd_acc;
    req(1'b0, $urandom, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_acc) bus.req_addr = $urandom;
    end
    chk("t3_acc4", n_rd_acc - start, 4);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (last_acc) bus.req_valid = 1'b0;
    end
    chk("t3_acc5", n_rd_acc - start, 5);

    // read accepted while a write completes
    req(1'b1, 32'h80, $urandom, 4'h3);
    tick();
    req(1'b0, 32'h209, 32'h0, 4'hF);
    tick();
    chk("t4_b2b", last_acc, 1);
    bus.req_valid = 1'b0;
    repeat (6) tick();

    // spurious readdatavalid
    bus.av_readdatavalid = 1'b1;
    bus.av_readdata = 32'hDEADBEEF;
    tick();
    repeat (3) tick();
    chk("t5_err", err, 1);

    // reset with reads in flight
    bus.rsp_ready = 1'b0;
    lat_force = 8;
    req(1'b0, 32'h11, 32'h0, 4'hF);
    tick();
    req(1'b0, 32'h22, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    tick();
    do_reset(2, 1'b1);
    repeat (10) tick();
    chk("t6_late_err", err, 1);
    start = n_rd_acc;
    req(1'b0, $urandom, 32'h0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (last_acc) bus.req_addr = $urandom;
    end
    chk("t6_credits", n_rd_acc - start, MAXP);
    lat_force = 0;
    do_reset(2, 1'b0);

    // random traffic
    force_wr = -1;
    for (int i = 0; i < 1500; i++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      req($urandom_range(0, 2) == 0, $urandom, $urandom,
          4'($urandom_range(0, 15)));
      bus.req_valid = ($urandom_range(0, 1) == 1);
      tick();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    force_wr = 0;
    repeat (20) tick();
    chk("drain_valid", bus.rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
